// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and unified memory.
// The controller drives the request side through the master modport; memory answers on mem_ready.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic MemWrite;
  logic AdrSrc;

  modport master (
    output mem_req,
    output MemWrite,
    output AdrSrc,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  MemWrite,
    input  AdrSrc,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core.
// Drives datapath enables/muxes from op/funct3 and the ALU flags, and handshakes
// unified memory through multicycle_controller_if (mem_req / mem_ready).
// Optional macro MC_PERF_CNT_EN builds the retired-instruction and cycle counters;
// without it both counter ports read zero.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC <= PC+4 on ready
// S_DECODE   | OldPC+imm into ALUOut, dispatch on op
// S_MEMADR   | RD1+imm address for load/store
// S_MEMREAD  | load access at ALUOut
// S_MEMWB    | write load data to regfile
// S_MEMWRITE | store access at ALUOut
// S_EXECR    | register-register ALU op
// S_EXECI    | register-immediate ALU op
// S_ALUWB    | write ALUOut to regfile
// S_BRANCH   | compare, PC <= branch target when taken
// S_JAL      | PC <= target, ALU forms OldPC+4 link
// S_JALR_ADR | RD1+imm jump target
// S_JALR_LNK | PC <= target, ALU forms OldPC+4 link
// S_UPPER    | lui/auipc write-back
// S_TRAP     | illegal opcode or bus timeout, held until reset
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master mem,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    Zero,
  input  logic                    ALUR31,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    RegWrite,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              ImmSrc,
  output logic [1:0]              ResultSrc,
  output logic                    illegal_op,
  output logic                    bus_err,
  output logic [31:0]             instret,
  output logic [31:0]             cycles
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR,
    S_JALR_LNK, S_UPPER, S_TRAP
  } state_t;

  localparam bit               TIMEOUT_EN = (MEM_WAIT_MAX != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST  = TIMEOUT_EN ? CNT_W'(MEM_WAIT_MAX - 1) : '0;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_mem, timeout, take;
  logic             mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  assign in_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = TIMEOUT_EN && in_mem && !mem.mem_ready && (wait_cnt == WAIT_LAST);
  // funct3[2] picks signed/unsigned-less-than flag vs equality; funct3[0] inverts the sense
  assign take    = funct3[0] ^ (funct3[2] ? ALUR31 : Zero);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // memory wait counter: restarts whenever the access completes or the state changes
  always_ff @(posedge clk) begin
    if (!reset)                                    wait_cnt <= '0;
    else if (state_next != state || mem.mem_ready) wait_cnt <= '0;
    else if (in_mem)                               wait_cnt <= wait_cnt + 1'b1;
  end

  // sticky fault flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (state == S_DECODE && state_next == S_TRAP) illegal_op <= 1'b1;
      if (timeout)                                  bus_err    <= 1'b1;
    end
  end

  // next-state and Moore output decode
  always_comb begin
    state_next  = state;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem.AdrSrc  = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1100011:             state_next = S_BRANCH;
          7'b1101111:             state_next = S_JAL;
          7'b1100111:             state_next = S_JALR_ADR;
          7'b0110111, 7'b0010111: state_next = S_UPPER;
          default:                state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c  = 1'b1;
        mem.AdrSrc = 1'b1;
        if (mem.mem_ready) state_next = S_MEMWB;
        else if (timeout)  state_next = S_TRAP;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        mem.AdrSrc  = 1'b1;
        if (mem.mem_ready) state_next = S_FETCH;
        else if (timeout)  state_next = S_TRAP;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        pc_write_c = take;
        state_next = S_FETCH;
      end
      S_JAL, S_JALR_LNK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR_ADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_JALR_LNK;
      end
      S_UPPER: begin
        ResultSrc   = 2'b11;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_TRAP;
    endcase
  end

  // immediate format follows the opcode regardless of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // strobes are forced low while reset is held so a mid-access reset writes nothing
  assign mem.mem_req  = mem_req_c   & reset;
  assign mem.MemWrite = mem_write_c & reset;
  assign IRWrite      = ir_write_c  & reset;
  assign PCWrite      = pc_write_c  & reset;
  assign RegWrite     = reg_write_c & reset;

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q, cycles_q;
  logic        retire;

  assign retire = (state_next == S_FETCH) &&
                  ((state == S_ALUWB) || (state == S_MEMWB) || (state == S_MEMWRITE) ||
                   (state == S_BRANCH) || (state == S_UPPER));

  // free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`else
  assign instret = 32'd0;
  assign cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its expected
// per-cycle control words and mem_ready stimulus, then the queue is drained cycle by cycle.
module tb_multicycle_controller;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        Zero, ALUR31;
  logic        IRWrite, PCWrite, RegWrite, illegal_op, bus_err;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc;
  logic [31:0] instret, cycles;

  multicycle_controller_if mif ();

  multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mif),
    .op         (op),
    .funct3     (funct3),
    .Zero       (Zero),
    .ALUR31     (ALUR31),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .instret    (instret),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_idx  = 0;
  logic [13:0] exp_q[$];
  bit          stim_q[$];
  logic [31:0] exp_instret = 0;
  logic [31:0] exp_cycles  = 0;
  logic [13:0] obs_w;

  assign obs_w = {mif.mem_req, mif.MemWrite, mif.AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc};

  // reference cycle count: cleared by each reset edge, +1 on every other edge
  always @(posedge clk) begin
    if (!reset) exp_cycles <= 0;
    else        exp_cycles <= exp_cycles + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, A, B, ALUOp, ResultSrc}
  function automatic logic [13:0] mk(bit mreq, bit mw, bit adr, bit irw, bit pcw, bit rw,
                                     logic [1:0] a, logic [1:0] b, logic [1:0] aop,
                                     logic [1:0] rs);
    return {mreq, mw, adr, irw, pcw, rw, a, b, aop, rs};
  endfunction

  function automatic logic [1:0] imm_exp(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit branch_taken(logic [2:0] f3, bit z, bit r31);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return r31;
      3'b101:  return !r31;
      3'b110:  return r31;
      3'b111:  return !r31;
      default: return z;
    endcase
  endfunction

  task automatic push(input logic [13:0] w, input bit rdy);
    exp_q.push_back(w);
    stim_q.push_back(rdy);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // called at posedge+1: drive this cycle's stimulus, compare at negedge, advance
  task automatic drain(input string name);
    logic [13:0] w;
    while (stim_q.size() > 0) begin
      mif.mem_ready = stim_q.pop_front();
      @(negedge clk);
      w = exp_q.pop_front();
      check_val($sformatf("%s ctl c%0d", name, cyc_idx), 32'(obs_w), 32'(w));
      check_val($sformatf("%s imm c%0d", name, cyc_idx), 32'(ImmSrc), 32'(imm_exp(op)));
      cyc_idx++;
      @(posedge clk);
      #1;
    end
    cyc_idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mif.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst strobes", 32'({mif.mem_req, mif.MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
    check_val("rst illegal_op", 32'(illegal_op), 32'd0);
    check_val("rst bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_instret = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef MC_PERF_CNT_EN
    check_val({tag, " instret"}, instret, exp_instret);
    check_val({tag, " cycles"}, cycles, exp_cycles);
`else
    check_val({tag, " instret"}, instret, 32'd0);
    check_val({tag, " cycles"}, cycles, 32'd0);
`endif
  endtask

  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input bit z, input bit r31, input int fwait, input int mwait);
    logic [13:0] dec, aluwb, jal;
    op = o; funct3 = f3; Zero = z; ALUR31 = r31;
    dec   = mk(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00);
    aluwb = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    jal   = mk(0,0,0,0,1,0, 2'b01, 2'b10, 2'b00, 2'b00);
    repeat (fwait) push(mk(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b0);
    push(mk(1,0,0,1,1,0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b1);
    push(dec, rnd());
    case (o)
      7'b0000011: begin
        push(mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00), rnd());
        repeat (mwait) push(mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
        push(mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1);
        push(mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b01), rnd());
        exp_instret++;
      end
      7'b0100011: begin
        push(mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00), rnd());
        repeat (mwait) push(mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
        push(mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1);
        exp_instret++;
      end
      7'b0110011: begin
        push(mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00), rnd());
        push(aluwb, rnd());
        exp_instret++;
      end
      7'b0010011: begin
        push(mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b10, 2'b00), rnd());
        push(aluwb, rnd());
        exp_instret++;
      end
      7'b1100011: begin
        push(mk(0,0,0,0,branch_taken(f3, z, r31),0, 2'b10, 2'b00, 2'b01, 2'b00), rnd());
        exp_instret++;
      end
      7'b1101111: begin
        push(jal, rnd());
        push(aluwb, rnd());
        exp_instret++;
      end
      7'b1100111: begin
        push(mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00), rnd());
        push(jal, rnd());
        push(aluwb, rnd());
        exp_instret++;
      end
      7'b0110111, 7'b0010111: begin
        push(mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11), rnd());
        exp_instret++;
      end
      default: begin
        push(14'd0, rnd());
        push(14'd0, rnd());
      end
    endcase
    drain(name);
  endtask

  initial begin
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; Zero = 1'b0; ALUR31 = 1'b0;
    mif.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr("add",   7'b0110011, 3'b000, 0, 0, 0, 0);
    run_instr("addi",  7'b0010011, 3'b000, 0, 0, 2, 0);
    run_instr("lw",    7'b0000011, 3'b010, 0, 0, 0, 3);
    run_instr("sw",    7'b0100011, 3'b010, 0, 0, 0, 1);
    run_instr("beq",   7'b1100011, 3'b000, 1, 0, 0, 0);
    run_instr("bne",   7'b1100011, 3'b001, 1, 0, 0, 0);
    run_instr("bltu",  7'b1100011, 3'b110, 0, 1, 0, 0);
    run_instr("bgeu",  7'b1100011, 3'b111, 0, 1, 0, 0);
    run_instr("blt",   7'b1100011, 3'b100, 0, 0, 0, 0);
    run_instr("bge",   7'b1100011, 3'b101, 1, 0, 0, 0);
    run_instr("jal",   7'b1101111, 3'b000, 0, 0, 0, 0);
    run_instr("jalr",  7'b1100111, 3'b000, 0, 0, 0, 0);
    run_instr("lui",   7'b0110111, 3'b000, 0, 0, 0, 0);
    run_instr("auipc", 7'b0010111, 3'b000, 0, 0, 0, 0);
    check_perf("mix");
    check_val("mix illegal_op", 32'(illegal_op), 32'd0);
    check_val("mix bus_err", 32'(bus_err), 32'd0);

    run_instr("illegal", 7'b1111111, 3'b000, 0, 0, 0, 0);
    check_val("trap illegal_op", 32'(illegal_op), 32'd1);
    check_val("trap bus_err", 32'(bus_err), 32'd0);
    do_reset();

    op = 7'b0110011;
    repeat (WAIT_MAX) push(mk(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b0);
    push(14'd0, 1'b0);
    push(14'd0, 1'b1);
    drain("timeout");
    check_val("timeout bus_err", 32'(bus_err), 32'd1);
    check_val("timeout illegal_op", 32'(illegal_op), 32'd0);
    do_reset();

    for (int i = 0; i < 10; i++) run_instr("add10", 7'b0110011, 3'b000, 0, 0, 0, 0);
    check_perf("add10");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
